cnt_readout_ctrl: RTL and testbench

//  Read-side controller for the 32-bit pixel event counter. Generates the periodic readDataClock

---
 rtl/cnt_pkg.sv | 19 +
 rtl/cnt_readout_ctrl_if.sv | 8 +
 rtl/cnt_spi_tx.sv | 48 ++++
 rtl/cnt_readout_ctrl.sv | 78 +++++++
 tb/tb_cnt_readout_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants, FSM state type and CRC helper for the counter readout path.
// Optional CRC trailer enabled by defining CNT_READOUT_CRC_EN.
package cnt_pkg;
  localparam int CNT_W = 32;
  localparam logic [7:0] CRC8_POLY = 8'h07;
`ifdef CNT_READOUT_CRC_EN
  localparam int FRAME_W = CNT_W + 8;
  function automatic logic [7:0] crc8(input logic [CNT_W-1:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = CNT_W - 1; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? CRC8_POLY : 8'h00);
    return c;
  endfunction
`else
  localparam int FRAME_W = CNT_W;
`endif
  localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
  typedef enum logic [2:0] {IDLE, STROBE, SETTLE, LOAD, GATE} stateT;
endpackage

// File: rtl/cnt_readout_ctrl_if.sv
// cnt_readout_ctrl_if: host SPI link between the MCU (master) and the readout controller (slave).
interface cnt_readout_ctrl_if;
  logic spiSck;
  logic spiCsN;
  logic spiMiso;
  modport master(output spiSck, spiCsN, input spiMiso);
  modport slave(input spiSck, spiCsN, output spiMiso);
endinterface

// File: rtl/cnt_spi_tx.sv
// cnt_spi_tx: SPI-slave mode-0 transmitter; synchronises the host pins and shifts a frame out MSB first.
module cnt_spi_tx
  import cnt_pkg::*;
(
  input  logic               refClock,
  input  logic               rstCounter,
  input  logic [FRAME_W-1:0] frameWord,
  cnt_readout_ctrl_if.slave  spi,
  output logic               csFall
);
  localparam logic [BIT_CNT_W-1:0] FRAME_LEN = BIT_CNT_W'(FRAME_W);
  logic [1:0] sckSync, csSync;
  logic sckPrev, csPrev, sckRise, sckFall;
  logic [FRAME_W-1:0] shiftReg;
  logic [BIT_CNT_W-1:0] bitCnt;
  assign csFall = csPrev & ~csSync[1];
  assign sckRise = ~sckPrev & sckSync[1] & ~csSync[1];
  assign sckFall = sckPrev & ~sckSync[1] & ~csSync[1];
  // shiftReg holds the bits still to come; spiMiso carries the current one
  always_ff @(posedge refClock or posedge rstCounter)
    if (rstCounter) begin
      sckSync <= '0;
      csSync <= '1;
      sckPrev <= 1'b0;
      csPrev <= 1'b1;
      shiftReg <= '0;
      bitCnt <= '0;
      spi.spiMiso <= 1'b0;
    end else begin
      sckSync <= {sckSync[0], spi.spiSck};
      csSync <= {csSync[0], spi.spiCsN};
      sckPrev <= sckSync[1];
      csPrev <= csSync[1];
      if (csFall) begin
        shiftReg <= frameWord << 1;
        bitCnt <= '0;
        spi.spiMiso <= frameWord[FRAME_W-1];
      end else if (csSync[1]) begin
        spi.spiMiso <= 1'b0;
      end else begin
        if (sckRise && bitCnt != FRAME_LEN) bitCnt <= bitCnt + 1'b1;
        if (sckFall) begin
          shiftReg <= shiftReg << 1;
          spi.spiMiso <= (bitCnt < FRAME_LEN) ? shiftReg[FRAME_W-1] : 1'b0;
        end
      end
    end
endmodule

// File: rtl/cnt_readout_ctrl.sv
// cnt_readout_ctrl: periodic latch strobe, settle-delayed capture and SPI readout of the pixel counter.
// Defining CNT_READOUT_CRC_EN appends a CRC-8 byte to every frame.
module cnt_readout_ctrl
  import cnt_pkg::*;
#(
  parameter int GATE_CYCLES   = 1000000,
  parameter int STROBE_HIGH   = 4,
  parameter int SETTLE_CYCLES = 6
) (
  input  logic             refClock,
  input  logic             rstCounter,
  input  logic             enReadout,
  input  logic [CNT_W-1:0] cntOutValue,
  output logic             readDataClock,
  cnt_readout_ctrl_if.slave spi,
  output logic             dataReady,
  output logic             overrun
);
  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam int PW = $clog2(STROBE_HIGH + SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0] STROBE_LAST = PW'(STROBE_HIGH - 1);
  localparam logic [PW-1:0] LOAD_AT = PW'(SETTLE_CYCLES - 2);
  stateT state, nextState;
  logic [TW-1:0] gateTimer;
  logic [PW-1:0] phase;
  logic [CNT_W-1:0] hold;
  logic [FRAME_W-1:0] frameWord;
  logic csFall, strobeStart, isLoad;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = enReadout ? STROBE : IDLE;
      STROBE:  nextState = (phase >= STROBE_LAST) ? SETTLE : STROBE;
      SETTLE:  nextState = (phase >= LOAD_AT) ? LOAD : SETTLE;
      LOAD:    nextState = GATE;
      GATE:    nextState = (gateTimer == '0) ? (enReadout ? STROBE : IDLE) : GATE;
      default: nextState = IDLE;
    endcase
    strobeStart = (nextState == STROBE) && (state != STROBE);
    isLoad = state == LOAD;
  end
  // strobe and gate timer are both keyed to the registered strobe rise, so the period is exact
  always_ff @(posedge refClock or posedge rstCounter)
    if (rstCounter) begin
      state <= IDLE;
      readDataClock <= 1'b0;
      gateTimer <= '0;
      phase <= '0;
      hold <= '0;
      dataReady <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= nextState;
      readDataClock <= nextState == STROBE;
      gateTimer <= strobeStart ? GATE_LOAD : (gateTimer != '0) ? gateTimer - 1'b1 : gateTimer;
      phase <= strobeStart ? '0 : (state == STROBE || state == SETTLE) ? phase + 1'b1 : phase;
      if (isLoad) hold <= cntOutValue;
      dataReady <= isLoad | (dataReady & ~csFall);
      overrun <= ~csFall & (overrun | (isLoad & dataReady));
    end
`ifdef CNT_READOUT_CRC_EN
  logic [7:0] crcReg;
  always_ff @(posedge refClock or posedge rstCounter)
    if (rstCounter) crcReg <= '0;
    else if (isLoad) crcReg <= crc8(cntOutValue);
  assign frameWord = {hold, crcReg};
`else
  assign frameWord = hold;
`endif
  cnt_spi_tx spiTx (
    .refClock(refClock),
    .rstCounter(rstCounter),
    .frameWord(frameWord),
    .spi(spi),
    .csFall(csFall)
  );
endmodule

// File: tb/tb_cnt_readout_ctrl.sv
// tb_cnt_readout_ctrl: directed, table-driven bench for the counter readout controller.
// With CNT_READOUT_CRC_EN defined the expected frames include the CRC byte.
module tb_cnt_readout_ctrl;
  import cnt_pkg::*;
  logic refClock = 1'b0;
  logic rstCounter, enReadout, readDataClock, dataReady, overrun;
  logic [CNT_W-1:0] cntOutValue;
  logic [FRAME_W-1:0] f;
  int errors = 0, checks = 0;
  cnt_readout_ctrl_if spi();
  cnt_readout_ctrl #(.GATE_CYCLES(100)) dut (
    .refClock(refClock),
    .rstCounter(rstCounter),
    .enReadout(enReadout),
    .cntOutValue(cntOutValue),
    .readDataClock(readDataClock),
    .spi(spi.slave),
    .dataReady(dataReady),
    .overrun(overrun)
  );
  always #5 refClock = ~refClock;
  typedef struct {
    logic [31:0] first;
    logic [31:0] second;
    bit twoCaps;
    bit expOverrun;
    logic [31:0] expWord;
  } vecT;
  vecT vecs[6];
  function automatic logic [FRAME_W-1:0] expFrame(input logic [CNT_W-1:0] w);
`ifdef CNT_READOUT_CRC_EN
    logic [7:0] c;
    c = '0;
    for (int i = CNT_W - 1; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ w[i]) ? 8'h07 : 8'h00);
    return {w, c};
`else
    return w;
`endif
  endfunction
  task automatic tick();
    @(negedge refClock);
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic waitStrobe();
    int n = 0;
    while (readDataClock !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("strobeSeen", readDataClock, 1);
  endtask
  task automatic spiRead(output logic [FRAME_W-1:0] fr);
    fr = '0;
    spi.spiCsN = 1'b0;
    repeat (8) tick();
    chk("dataReadyAtCsFall", dataReady, 0);
    chk("overrunAtCsFall", overrun, 0);
    for (int i = 0; i < FRAME_W; i++) begin
      spi.spiSck = 1'b1;
      fr = {fr[FRAME_W-2:0], spi.spiMiso};
      repeat (4) tick();
      spi.spiSck = 1'b0;
      repeat (4) tick();
    end
    for (int i = 0; i < 2; i++) begin
      spi.spiSck = 1'b1;
      chk("misoAfterFrame", spi.spiMiso, 0);
      repeat (4) tick();
      spi.spiSck = 1'b0;
      repeat (4) tick();
    end
    spi.spiCsN = 1'b1;
    repeat (4) tick();
    chk("misoCsHigh", spi.spiMiso, 0);
  endtask
  task automatic capture(input logic [31:0] v);
    cntOutValue = v;
    enReadout = 1'b1;
    waitStrobe();
    enReadout = 1'b0;
    repeat (10) tick();
  endtask
  initial begin
    int highs;
    vecs[0] = '{32'hA5A5_0F0F, 32'h0, 1'b0, 1'b0, 32'hA5A5_0F0F};
    vecs[1] = '{32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[3] = '{32'h0000_0001, 32'h0, 1'b0, 1'b0, 32'h0000_0001};
    vecs[4] = '{32'h8000_0001, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678};
    vecs[5] = '{32'h0000_0000, 32'h0, 1'b0, 1'b0, 32'h0000_0000};
    rstCounter = 1'b1;
    enReadout = 1'b0;
    cntOutValue = '0;
    spi.spiSck = 1'b0;
    spi.spiCsN = 1'b1;
    repeat (3) tick();
    chk("rstStrobe", readDataClock, 0);
    chk("rstDataReady", dataReady, 0);
    chk("rstOverrun", overrun, 0);
    chk("rstMiso", spi.spiMiso, 0);
    rstCounter = 1'b0;
    repeat (3) tick();
    chk("idleStrobe", readDataClock, 0);
    // periodic strobe, capture timing and overrun from an unread second capture
    cntOutValue = 32'h0000_1234;
    enReadout = 1'b1;
    waitStrobe();
    for (int k = 0; k < 200; k++) begin
      chk("periodStrobe", readDataClock, ((k % 100) < 4) ? 1 : 0);
      chk("periodDataReady", dataReady, (k >= 6) ? 1 : 0);
      chk("periodOverrun", overrun, (k >= 106) ? 1 : 0);
      if (k == 199) enReadout = 1'b0;
      tick();
    end
    highs = 0;
    for (int k = 0; k < 250; k++) begin
      if (readDataClock) highs++;
      tick();
    end
    chk("noStrobeAfterStop", highs, 0);
    spiRead(f);
    chk("flushFrame", f, expFrame(32'h0000_1234));
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].twoCaps) begin
        cntOutValue = vecs[v].first;
        enReadout = 1'b1;
        waitStrobe();
        repeat (10) tick();
        cntOutValue = vecs[v].second;
        waitStrobe();
        enReadout = 1'b0;
        repeat (10) tick();
      end else capture(vecs[v].first);
      chk("vecDataReady", dataReady, 1);
      chk("vecOverrun", overrun, vecs[v].expOverrun);
      spiRead(f);
      chk("vecFrame", f, expFrame(vecs[v].expWord));
    end
    // capture during an active frame leaves the frame untouched
    capture(32'h1);
    fork
      spiRead(f);
      begin
        repeat (20) tick();
        cntOutValue = 32'h2;
        enReadout = 1'b1;
        waitStrobe();
        enReadout = 1'b0;
      end
    join
    chk("midFrameFrame", f, expFrame(32'h1));
    repeat (2) tick();
    chk("midFrameDataReady", dataReady, 1);
    chk("midFrameOverrun", overrun, 0);
    spiRead(f);
    chk("midFrameNext", f, expFrame(32'h2));
    // enable dropped one cycle after strobe rise
    cntOutValue = 32'h5555_AAAA;
    enReadout = 1'b1;
    waitStrobe();
    tick();
    enReadout = 1'b0;
    for (int k = 1; k < 260; k++) begin
      chk("dropStrobe", readDataClock, (k < 4) ? 1 : 0);
      chk("dropDataReady", dataReady, (k >= 6) ? 1 : 0);
      tick();
    end
    spiRead(f);
    chk("dropFrame", f, expFrame(32'h5555_AAAA));
`ifdef CNT_READOUT_CRC_EN
    capture(32'h1);
    spiRead(f);
    chk("crcByte", f[7:0], 8'h07);
`endif
    // reset in the middle of a frame
    capture(32'hC3C3_C3C3);
    spi.spiCsN = 1'b0;
    repeat (8) tick();
    spi.spiSck = 1'b1;
    chk("misoBit31", spi.spiMiso, 1);
    repeat (4) tick();
    spi.spiSck = 1'b0;
    repeat (4) tick();
    chk("misoBit30", spi.spiMiso, 1);
    rstCounter = 1'b1;
    tick();
    chk("rstMidMiso", spi.spiMiso, 0);
    chk("rstMidDataReady", dataReady, 0);
    chk("rstMidOverrun", overrun, 0);
    chk("rstMidStrobe", readDataClock, 0);
    spi.spiSck = 1'b1;
    repeat (4) tick();
    chk("rstMidMisoSck", spi.spiMiso, 0);
    spi.spiSck = 1'b0;
    spi.spiCsN = 1'b1;
    rstCounter = 1'b0;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
